// File: rtl/seg_scan_display.sv
// seg_scan_display: time-multiplexed hex 7-segment scanner with dp, blank, leading-zero suppression and blink
module seg_scan_display #(
  parameter int NUM_DIGITS = 8,
  parameter int SCAN_DIV = 40000,
  parameter int BLINK_SLOTS = 256,
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      wr_en,
  input  logic [1:0]                wr_sel,
  input  logic [4*NUM_DIGITS-1:0]   wr_data,
  output logic [NUM_DIGITS-1:0]     dig_n,
  output logic [7:0]                seg_n,
  output logic [IW-1:0]             busy_slot
);
  localparam int DW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
  localparam int BW = BLINK_SLOTS > 1 ? $clog2(BLINK_SLOTS) : 1;
  localparam logic [6:0] SEG [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h27,
                                      7'h7F, 7'h67, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  logic [DW-1:0] div_q, div_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [BW-1:0] blink_q, blink_d;
  logic off_q, off_d;
  logic [4*NUM_DIGITS-1:0] val_q, val_d;
  logic [NUM_DIGITS-1:0] dp_q, dp_d, blank_q, blank_d, bm_q, bm_d, nz, dig_q, dig_d;
  logic lz_q, lz_d, ben_q, ben_d;
  logic [7:0] seg_q, seg_d;
  logic tick, bwrap, dark, acc;
  always_comb begin
    tick = div_q == DW'(SCAN_DIV - 1);
    div_d = tick ? '0 : div_q + 1'b1;
    idx_d = tick ? (idx_q == IW'(NUM_DIGITS - 1) ? '0 : idx_q + 1'b1) : idx_q;
    bwrap = tick && blink_q == BW'(BLINK_SLOTS - 1);
    blink_d = bwrap ? '0 : blink_q + BW'(tick);
    off_d = off_q ^ bwrap;
    val_d = wr_en && wr_sel == 2'd0 ? wr_data : val_q;
    dp_d = wr_en && wr_sel == 2'd1 ? wr_data[NUM_DIGITS-1:0] : dp_q;
    blank_d = wr_en && wr_sel == 2'd2 ? wr_data[NUM_DIGITS-1:0] : blank_q;
    {bm_d, ben_d, lz_d} = wr_en && wr_sel == 2'd3 ? wr_data[NUM_DIGITS+1:0] : {bm_q, ben_q, lz_q};
    acc = 1'b0;
    nz = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      acc = acc | (|val_q[4*i +: 4]);
      nz[i] = acc;
    end
    dark = blank_q[idx_q] | (lz_q & (idx_q != '0) & ~nz[idx_q]) | (ben_q & bm_q[idx_q] & off_q);
    dig_d = tick || dark ? '1 : ~(NUM_DIGITS'(1) << idx_q);
    seg_d = ~{dp_q[idx_q], SEG[val_q[{idx_q, 2'b00} +: 4]]};
  end
  always_ff @(posedge clock) begin
    if (!reset) begin
      div_q <= '0;
      idx_q <= '0;
      blink_q <= '0;
      off_q <= 1'b0;
      val_q <= '0;
      dp_q <= '0;
      blank_q <= '0;
      bm_q <= '0;
      lz_q <= 1'b0;
      ben_q <= 1'b0;
      dig_q <= '1;
      seg_q <= 8'hFF;
    end else begin
      div_q <= div_d;
      idx_q <= idx_d;
      blink_q <= blink_d;
      off_q <= off_d;
      val_q <= val_d;
      dp_q <= dp_d;
      blank_q <= blank_d;
      bm_q <= bm_d;
      lz_q <= lz_d;
      ben_q <= ben_d;
      dig_q <= dig_d;
      seg_q <= seg_d;
    end
  end
  assign dig_n = dig_q;
  assign seg_n = seg_q;
  assign busy_slot = idx_q;
endmodule

// File: tb/tb_seg_scan_display.sv
// tb_seg_scan_display: directed and random checks of the scanner against a time-based reference model
module tb_seg_scan_display;
  logic clock = 1'b0, reset = 1'b0, wr_en = 1'b0;
  logic [1:0] wr_sel = 2'd0;
  logic [31:0] wr_data = '0;
  logic [7:0] dig_n, seg_n;
  logic [2:0] busy_slot;
  int total = 0, bad = 0, k = 0;
  logic [31:0] mval = '0;
  logic [7:0] mdp = '0, mblank = '0, mbm = '0;
  logic mlz = 1'b0, mben = 1'b0;
  logic [6:0] segt [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h27,
                            7'h7F, 7'h67, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  seg_scan_display #(.NUM_DIGITS(8), .SCAN_DIV(4), .BLINK_SLOTS(2)) dut (
    .clock(clock), .reset(reset), .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
    .dig_n(dig_n), .seg_n(seg_n), .busy_slot(busy_slot));
  always #5 clock = ~clock;
  task automatic cyc(input logic r, input logic we, input logic [1:0] ws, input logic [31:0] wd);
    logic [7:0] ed, es;
    logic [2:0] eb;
    logic dark;
    int s, i;
    reset = r;
    wr_en = we;
    wr_sel = ws;
    wr_data = wd;
    s = k;
    i = (s / 4) % 8;
    dark = mblank[i] || (mlz && i > 0 && (mval >> (4 * i)) == 0) || (mben && mbm[i] && ((s / 8) % 2 == 1));
    ed = (dark || s % 4 == 3) ? 8'hFF : ~(8'h01 << i);
    es = ~{mdp[i], segt[mval[4*i +: 4]]};
    @(posedge clock);
    if (!r) begin
      {mval, mdp, mblank, mbm, mlz, mben} = '0;
      k = 0;
      ed = 8'hFF;
      es = 8'hFF;
    end else begin
      if (we) begin
        if (ws == 2'd0) mval = wd;
        else if (ws == 2'd1) mdp = wd[7:0];
        else if (ws == 2'd2) mblank = wd[7:0];
        else {mbm, mben, mlz} = wd[9:0];
      end
      k++;
    end
    eb = 3'((k / 4) % 8);
    #1;
    total++;
    assert (dig_n === ed) else begin bad++; $error("FAIL dig_n k=%0d got=%h exp=%h", k, dig_n, ed); end
    total++;
    assert (seg_n === es) else begin bad++; $error("FAIL seg_n k=%0d got=%h exp=%h", k, seg_n, es); end
    total++;
    assert (busy_slot === eb) else begin bad++; $error("FAIL busy_slot k=%0d got=%0d exp=%0d", k, busy_slot, eb); end
  endtask
  task automatic idle(input int n);
    for (int j = 0; j < n; j++) cyc(1'b1, 1'b0, 2'd0, 32'h0);
  endtask
  initial begin
    cyc(1'b0, 1'b0, 2'd0, 32'h0);
    cyc(1'b0, 1'b1, 2'd0, 32'hDEADBEEF);
    idle(40);
    cyc(1'b1, 1'b1, 2'd0, 32'h1234ABCD);
    idle(34);
    cyc(1'b1, 1'b1, 2'd3, 32'h1);
    cyc(1'b1, 1'b1, 2'd0, 32'h000000A5);
    idle(34);
    cyc(1'b1, 1'b1, 2'd0, 32'h0);
    idle(34);
    cyc(1'b1, 1'b1, 2'd3, 32'h0);
    cyc(1'b1, 1'b1, 2'd1, 32'h04);
    cyc(1'b1, 1'b1, 2'd2, 32'h80);
    cyc(1'b1, 1'b1, 2'd0, 32'h89ABCDEF);
    idle(34);
    cyc(1'b1, 1'b1, 2'd2, 32'h0);
    cyc(1'b1, 1'b1, 2'd3, 32'h6);
    idle(80);
    while (k % 4 != 3) cyc(1'b1, 1'b0, 2'd0, 32'h0);
    cyc(1'b1, 1'b1, 2'd0, 32'h76543210);
    idle(6);
    while (!((k / 4) % 8 == 5 && k % 4 == 1)) cyc(1'b1, 1'b0, 2'd0, 32'h0);
    cyc(1'b0, 1'b1, 2'd0, 32'hFFFFFFFF);
    idle(40);
    for (int j = 0; j < 600; j++)
      cyc(($urandom % 150) != 0, ($urandom % 5) == 0, 2'($urandom),
          ($urandom % 2) ? $urandom : $urandom % 256);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
